// File: rtl/fpu_seq.sv
// Issue/sequencing stage in front of the FPU datapath: holds one request on the FPU
// inputs, waits out the per-op latency, then returns the tagged result. Optional flush: FPU_SEQ_FLUSH_EN.
module fpu_seq #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 5,
    parameter int unsigned LAT_SQRT = 5,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    input  logic [4:0]  req_rd,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_src0,
    output logic [31:0] fpu_src1,
    input  logic [31:0] fpu_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_rd
`ifdef FPU_SEQ_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  fpu_op_q;
    logic [31:0] fpu_src0_q;
    logic [31:0] fpu_src1_q;
    logic [4:0]  rd_q;
    logic [31:0] resp_result_q;
    logic [4:0]  resp_rd_q;

    logic [3:0]  lat_d;
    logic [31:0] result_d;
    logic        flush_act;

`ifdef FPU_SEQ_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    always_comb begin
        lat_d = 4'd1;
        unique case (req_op)
            4'd0, 4'd1:   lat_d = 4'(LAT_ADD);
            4'd2:         lat_d = 4'(LAT_MUL);
            4'd3:         lat_d = 4'(LAT_DIV);
            4'd4:         lat_d = 4'(LAT_SQRT);
            4'd11, 4'd12: lat_d = 4'(LAT_CVT);
            default:      lat_d = 4'd1;
        endcase
    end

    // Ops 13..15 have no FPU meaning, so whatever the datapath produces is masked.
    assign result_d = (fpu_op_q >= 4'd13) ? 32'd0 : fpu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            fpu_op_q      <= 4'd0;
            fpu_src0_q    <= 32'd0;
            fpu_src1_q    <= 32'd0;
            rd_q          <= 5'd0;
            resp_result_q <= 32'd0;
            resp_rd_q     <= 5'd0;
        end else if (flush_act && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        fpu_op_q   <= req_op;
                        fpu_src0_q <= req_src0;
                        fpu_src1_q <= req_src1;
                        rd_q       <= req_rd;
                        cnt_q      <= lat_d;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd1) begin
                        resp_result_q <= result_d;
                        resp_rd_q     <= rd_q;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !flush_act;
    assign resp_valid  = (state_q == S_DONE);
    assign fpu_op      = fpu_op_q;
    assign fpu_src0    = fpu_src0_q;
    assign fpu_src1    = fpu_src1_q;
    assign resp_result = resp_result_q;
    assign resp_rd     = resp_rd_q;

endmodule
